spi_engine: RTL and testbench

//   SPI master engine serving the core's byte-wide SPI register port (spi_wren/spi_do/spi_cs_n in, spi_dsr/spi_di out).

---
 rtl/spi_engine_pkg.sv | 6 +
 rtl/spi_engine_sckgen.sv | 17 +
 rtl/spi_engine.sv | 90 +++++++++
 tb/tb_spi_engine.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_engine_pkg.sv
// spi_engine_pkg: shared FSM encodings and idle constants for the SPI master engine
package spi_engine_pkg;
  typedef enum logic [1:0] {SPI_IDLE = 2'd0, SPI_LO = 2'd1, SPI_HI = 2'd2} spi_state_e;
  localparam logic [7:0] SPI_IDLE_BYTE = 8'hFF;
  localparam logic SPI_MOSI_IDLE = 1'b1;
endpackage

// File: rtl/spi_engine_sckgen.sv
// spi_sckgen: ce-gated SCK half-period counter; tick strobes on the last ce tick of each half-period
module spi_sckgen #(
  parameter int CLKDIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic start,
  input  logic run,
  output logic tick
);
  logic [7:0] div;
  assign tick = ce & run & (div == 8'(CLKDIV - 1));
  always_ff @(posedge clk or posedge reset)
    if (reset) div <= '0;
    else if (ce) div <= (start || tick) ? '0 : run ? div + 8'd1 : div;
endmodule

// File: rtl/spi_engine.sv
// spi_engine: mode-0 MSB-first SPI master byte engine; define SPI_LOOPBACK_EN to sample MOSI instead of MISO
module spi_engine
  import spi_engine_pkg::*;
#(
  parameter int CLKDIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       wren_i,
  input  logic [7:0] data_i,
  input  logic       cs_n_i,
  output logic       dsr_o,
  output logic [7:0] data_o,
  output logic       sck_o,
  output logic       mosi_o,
  input  logic       miso_i,
  output logic       cs_n_o
);
  generate
    if (CLKDIV < 1 || CLKDIV > 255) begin : g_bad_clkdiv
      $error("spi_engine: CLKDIV must be within 1..255");
    end
  endgenerate
  spi_state_e state_q, state_d;
  logic [7:0] shreg_q, shreg_d, data_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic dsr_d, sck_d, mosi_d, start, tick, sample;
  assign start = ce & wren_i & (state_q == SPI_IDLE);
`ifdef SPI_LOOPBACK_EN
  assign sample = mosi_o;
`else
  assign sample = miso_i;
`endif
  spi_sckgen #(.CLKDIV(CLKDIV)) u_sckgen (
    .clk  (clk),
    .reset(reset),
    .ce   (ce),
    .start(start),
    .run  (state_q != SPI_IDLE),
    .tick (tick)
  );
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    dsr_d    = dsr_o;
    data_d   = data_o;
    sck_d    = sck_o;
    mosi_d   = mosi_o;
    if (start) begin
      shreg_d  = data_i;
      mosi_d   = data_i[7];
      bitcnt_d = 3'd7;
      dsr_d    = 1'b0;
      state_d  = SPI_LO;
    end else if (tick && state_q == SPI_LO) begin
      sck_d   = 1'b1;
      shreg_d = {shreg_q[6:0], sample};
      state_d = SPI_HI;
    end else if (tick && state_q == SPI_HI) begin
      sck_d    = 1'b0;
      bitcnt_d = bitcnt_q - 3'd1;
      mosi_d   = (bitcnt_q == 3'd0) ? SPI_MOSI_IDLE : shreg_q[7];
      data_d   = (bitcnt_q == 3'd0) ? shreg_q : data_o;
      dsr_d    = bitcnt_q == 3'd0;
      state_d  = (bitcnt_q == 3'd0) ? SPI_IDLE : SPI_LO;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q  <= SPI_IDLE;
      shreg_q  <= SPI_IDLE_BYTE;
      bitcnt_q <= '0;
      dsr_o    <= 1'b1;
      data_o   <= SPI_IDLE_BYTE;
      sck_o    <= 1'b0;
      mosi_o   <= SPI_MOSI_IDLE;
      cs_n_o   <= 1'b1;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      dsr_o    <= dsr_d;
      data_o   <= data_d;
      sck_o    <= sck_d;
      mosi_o   <= mosi_d;
      cs_n_o   <= ce ? cs_n_i : cs_n_o;
    end
endmodule

// File: tb/tb_spi_engine.sv
// tb_spi_engine: directed bench for spi_engine at CLKDIV=4 and CLKDIV=1 with a per-tick reference model
module tb_spi_engine;
`ifdef SPI_LOOPBACK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, wren_i = 1'b0, cs_n_i = 1'b1, ce_slow = 1'b0;
  logic [7:0] data_i = 8'h00, slave_byte = 8'h5A;
  logic [1:0] ph = 2'd0;
  logic ce;
  logic [1:0] dsr, sck, mosi, cso;
  logic [7:0] dat [2];
  int checks = 0, errors = 0;
  int rises [2];
  logic [7:0] rbits [2];
  int busy_tick [2];
  int busy_clk [2];

  always #5 clk = ~clk;
  always @(posedge clk) ph <= (ph == 2'd2) ? 2'd0 : ph + 2'd1;
  assign ce = ce_slow ? (ph == 2'd0) : 1'b1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  generate
    for (genvar k = 0; k < 2; k++) begin : g
      localparam int C = (k == 0) ? 4 : 1;
      logic miso;
      logic [7:0] slv = 8'hFF;
      logic sck_p = 1'b0;
      logic m_busy, m_cs;
      int m_n;
      logic [7:0] m_tx, m_rx, m_data;
      spi_engine #(.CLKDIV(C)) dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .wren_i(wren_i),
        .data_i(data_i),
        .cs_n_i(cs_n_i),
        .dsr_o (dsr[k]),
        .data_o(dat[k]),
        .sck_o (sck[k]),
        .mosi_o(mosi[k]),
        .miso_i(miso),
        .cs_n_o(cso[k])
      );
      // mode-0 slave: loads on accept, advances to the next bit after each SCK rise
      assign miso = slv[7];
      always @(posedge clk) begin
        if (ce && wren_i && dsr[k]) slv <= slave_byte;
        else if (!sck_p && sck[k]) slv <= {slv[6:0], 1'b1};
        sck_p <= sck[k];
      end
      // reference: n = ce ticks since the accepting tick; one bit every 2*C ticks, SCK high in the odd C-tick half
      always @(posedge clk or posedge reset)
        if (reset) begin
          m_busy <= 1'b0;
          m_n    <= 0;
          m_data <= 8'hFF;
          m_cs   <= 1'b1;
          m_tx   <= 8'h00;
          m_rx   <= 8'h00;
        end else if (ce) begin
          m_cs <= cs_n_i;
          if (!m_busy) begin
            if (wren_i) begin
              m_busy <= 1'b1;
              m_n    <= 0;
              m_tx   <= data_i;
              m_rx   <= LB ? data_i : slave_byte;
            end
          end else if (m_n + 1 == 16 * C) begin
            m_busy <= 1'b0;
            m_data <= m_rx;
          end else m_n <= m_n + 1;
        end
      always @(negedge clk)
        if (!reset) begin
          chk($sformatf("dsr%0d", k), 32'(dsr[k]), 32'(!m_busy));
          chk($sformatf("sck%0d", k), 32'(sck[k]), 32'(m_busy && ((m_n / C) % 2 == 1)));
          chk($sformatf("mosi%0d", k), 32'(mosi[k]), 32'(m_busy ? m_tx[7 - m_n / (2 * C)] : 1'b1));
          chk($sformatf("data%0d", k), 32'(dat[k]), 32'(m_data));
          chk($sformatf("cs%0d", k), 32'(cso[k]), 32'(m_cs));
        end
      always @(posedge sck[k]) begin
        rises[k] = rises[k] + 1;
        rbits[k] = {rbits[k][6:0], mosi[k]};
      end
      always @(posedge clk) begin
        if (ce && !dsr[k]) busy_tick[k] = busy_tick[k] + 1;
        if (!dsr[k]) busy_clk[k] = busy_clk[k] + 1;
      end
    end
  endgenerate

  task automatic clr();
    for (int i = 0; i < 2; i++) begin
      rises[i] = 0;
      rbits[i] = 8'h00;
      busy_tick[i] = 0;
      busy_clk[i] = 0;
    end
  endtask

  task automatic wr(input logic [7:0] d);
    @(negedge clk);
    while (!ce) @(negedge clk);
    wren_i = 1'b1;
    data_i = d;
    @(negedge clk);
    wren_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dsr != 2'b11 && n < 2000);
    chk("idle_timeout", 32'(dsr), 32'h3);
  endtask

  initial begin
    clr();
    repeat (3) @(negedge clk);
    chk("rst_dsr", 32'(dsr), 32'h3);
    chk("rst_data", 32'(dat[0]), 32'hFF);
    chk("rst_sck", 32'(sck), 32'h0);
    chk("rst_mosi", 32'(mosi), 32'h3);
    chk("rst_cs", 32'(cso), 32'h3);
    reset = 1'b0;
    // basic byte: A5 out, 5A back
    slave_byte = 8'h5A;
    clr();
    wr(8'hA5);
    wait_idle();
    chk("t1_mosi_bits", 32'(rbits[0]), 32'hA5);
    chk("t1_rises", 32'(rises[0]), 32'd8);
    chk("t1_busy", 32'(busy_tick[0]), 32'd64);
    chk("t1_data", 32'(dat[0]), LB ? 32'hA5 : 32'h5A);
    chk("t1_busy_div1", 32'(busy_tick[1]), 32'd16);
    chk("t1_data_div1", 32'(dat[1]), LB ? 32'hA5 : 32'h5A);
    // ce one cycle in three
    ce_slow = 1'b1;
    slave_byte = 8'hC3;
    clr();
    wr(8'h81);
    wait_idle();
    chk("t2_rises", 32'(rises[1]), 32'd8);
    chk("t2_busy_clk", 32'(busy_clk[1]), 32'd48);
    chk("t2_busy_tick", 32'(busy_tick[1]), 32'd16);
    chk("t2_mosi_after", 32'(mosi[1]), 32'd1);
    chk("t2_mosi_bits", 32'(rbits[1]), 32'h81);
    chk("t2_busy_clk_div4", 32'(busy_clk[0]), 32'd192);
    chk("t2_data", 32'(dat[1]), LB ? 32'h81 : 32'hC3);
    ce_slow = 1'b0;
    // write while busy is dropped
    slave_byte = 8'h96;
    clr();
    wr(8'hFF);
    repeat (8) @(negedge clk);
    wr(8'h00);
    wait_idle();
    chk("t3_rises0", 32'(rises[0]), 32'd8);
    chk("t3_rises1", 32'(rises[1]), 32'd8);
    chk("t3_mosi0", 32'(rbits[0]), 32'hFF);
    chk("t3_mosi1", 32'(rbits[1]), 32'hFF);
    chk("t3_data", 32'(dat[0]), LB ? 32'hFF : 32'h96);
    repeat (40) @(negedge clk);
    chk("t3_no_follow_dsr", 32'(dsr), 32'h3);
    chk("t3_no_follow_rises", 32'(rises[0]), 32'd8);
    // reset mid-transfer
    cs_n_i = 1'b0;
    slave_byte = 8'h5A;
    clr();
    wr(8'hA5);
    repeat (19) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t4_sck", 32'(sck[0]), 32'd0);
    chk("t4_mosi", 32'(mosi[0]), 32'd1);
    chk("t4_dsr", 32'(dsr[0]), 32'd1);
    chk("t4_data", 32'(dat[0]), 32'hFF);
    chk("t4_cs", 32'(cso[0]), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    cs_n_i = 1'b1;
    slave_byte = 8'h96;
    clr();
    wr(8'h69);
    wait_idle();
    chk("t4_clean_bits", 32'(rbits[0]), 32'h69);
    chk("t4_clean_rises", 32'(rises[0]), 32'd8);
    chk("t4_clean_data", 32'(dat[0]), LB ? 32'h69 : 32'h96);
    // chip select passthrough
    @(negedge clk);
    cs_n_i = 1'b0;
    chk("t5_cs_hold", 32'(cso), 32'h3);
    @(negedge clk);
    chk("t5_cs_low", 32'(cso), 32'h0);
    chk("t5_sck", 32'(sck), 32'h0);
    chk("t5_dsr", 32'(dsr), 32'h3);
    cs_n_i = 1'b1;
    @(negedge clk);
    chk("t5_cs_high", 32'(cso), 32'h3);
    // zero slave byte: only loopback returns the sent byte
    slave_byte = 8'h00;
    wr(8'h3C);
    wait_idle();
    chk("t6_data", 32'(dat[0]), LB ? 32'h3C : 32'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
